// File: rtl/pipe_hazard_if.sv
// pipe_hazard_if: hazard inputs from the pipeline and stall/flush controls back to it.
interface pipe_hazard_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic [REG_AW-1:0] id_rs1, id_rs2, ex_rd;
  logic              id_rs1_used, id_rs2_used, id_mc_op, ex_mem_read, branch_taken, mc_done;
  logic              pc_hold, ifid_hold, ifid_flush, idex_hold, idex_bubble, exmem_bubble;
  logic              mc_busy, mc_timeout;
  logic [CNT_W-1:0]  stall_cnt;
  modport master (
    output id_rs1, id_rs2, ex_rd, id_rs1_used, id_rs2_used, id_mc_op, ex_mem_read, branch_taken, mc_done,
    input  pc_hold, ifid_hold, ifid_flush, idex_hold, idex_bubble, exmem_bubble, mc_busy, mc_timeout, stall_cnt
  );
  modport slave (
    input  id_rs1, id_rs2, ex_rd, id_rs1_used, id_rs2_used, id_mc_op, ex_mem_read, branch_taken, mc_done,
    output pc_hold, ifid_hold, ifid_flush, idex_hold, idex_bubble, exmem_bubble, mc_busy, mc_timeout, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush control for load-use, EX redirects and multi-cycle EX ops.
module pipe_hazard_ctrl #(
  parameter int REG_AW     = 5,
  parameter int CNT_W      = 16,
  parameter int MC_TIMEOUT = 1024
) (
  input logic          clk,
  input logic          rst,
  pipe_hazard_if.slave bus
);
  localparam int WW = $clog2(MC_TIMEOUT + 1);
  localparam logic [WW-1:0] LAST = WW'(MC_TIMEOUT - 1);
  typedef enum logic {RUN, MC_WAIT} state_t;
  state_t            state, state_n;
  logic              mc_pend, pend_n, to_q, to_n;
  logic [WW-1:0]     wcnt, wcnt_n;
  logic [CNT_W-1:0]  cnt;
  logic [REG_AW-1:0] rd;
  logic              lu, in_wait, rel, hold, run_br, run_lu, hold_pc;
  assign rd = bus.ex_rd;
  always_comb begin
    lu = bus.ex_mem_read && rd != '0 &&
         ((bus.id_rs1_used && bus.id_rs1 == rd) || (bus.id_rs2_used && bus.id_rs2 == rd));
    in_wait = state == MC_WAIT;
    rel     = bus.mc_done || wcnt == LAST;
    hold    = in_wait && !rel;
    run_br  = !in_wait && bus.branch_taken;
    run_lu  = !in_wait && !bus.branch_taken && lu;
    // Controls are forced low while reset is asserted, whatever the inputs do.
    hold_pc          = rst && (hold || run_lu);
    bus.pc_hold      = hold_pc;
    bus.ifid_hold    = hold_pc;
    bus.ifid_flush   = rst && run_br;
    bus.idex_hold    = rst && hold;
    bus.idex_bubble  = rst && (run_br || run_lu);
    bus.exmem_bubble = rst && hold;
    bus.mc_busy      = rst && in_wait;
    state_n = in_wait ? (rel ? RUN : MC_WAIT) : ((mc_pend && !bus.branch_taken) ? MC_WAIT : RUN);
    pend_n  = !in_wait && !bus.branch_taken && !lu && !mc_pend && bus.id_mc_op;
    wcnt_n  = in_wait ? wcnt + 1'b1 : '0;
    to_n    = to_q || (in_wait && !bus.mc_done && wcnt == LAST);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state   <= RUN;
      mc_pend <= 1'b0;
      wcnt    <= '0;
      to_q    <= 1'b0;
      cnt     <= '0;
    end else begin
      state   <= state_n;
      mc_pend <= pend_n;
      wcnt    <= wcnt_n;
      to_q    <= to_n;
      cnt     <= cnt + CNT_W'(hold_pc && !(&cnt));
    end
  assign bus.mc_timeout = to_q;
  assign bus.stall_cnt  = cnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: vector table, directed multi-cycle sequences and random run vs. a cycle model.
module tb_pipe_hazard_ctrl;
  localparam int AW = 5, CW = 8, TO = 16;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  pipe_hazard_if #(.REG_AW(AW), .CNT_W(CW)) bus();
  pipe_hazard_ctrl #(.REG_AW(AW), .CNT_W(CW), .MC_TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  int total = 0, bad = 0;
  int m_wait = -1;
  bit m_pend = 1'b0, m_to = 1'b0;
  int m_cnt = 0;
  typedef struct {
    logic ld; logic [AW-1:0] rd, rs1, rs2; logic u1, u2, br; logic [3:0] want;
  } vec_t;
  vec_t vecs[8];

  // bit order: pc_hold ifid_hold ifid_flush idex_hold idex_bubble exmem_bubble mc_busy mc_timeout
  function automatic logic [7:0] ctl_vec();
    return {bus.pc_hold, bus.ifid_hold, bus.ifid_flush, bus.idex_hold,
            bus.idex_bubble, bus.exmem_bubble, bus.mc_busy, bus.mc_timeout};
  endfunction

  function automatic bit lu_now();
    return bus.ex_mem_read && bus.ex_rd != 0 &&
           ((bus.id_rs1_used && bus.id_rs1 == bus.ex_rd) || (bus.id_rs2_used && bus.id_rs2 == bus.ex_rd));
  endfunction

  function automatic logic [7:0] expect_ctl();
    bit r;
    if (m_wait >= 0) begin
      r = bus.mc_done || m_wait == TO - 1;
      return {!r, !r, 1'b0, !r, 1'b0, !r, 1'b1, m_to};
    end
    if (bus.branch_taken) return {7'b0010100, m_to};
    if (lu_now()) return {7'b1100100, m_to};
    return {7'b0, m_to};
  endfunction

  task automatic advance();
    logic [7:0] e;
    e = expect_ctl();
    if (e[7] && m_cnt < (1 << CW) - 1) m_cnt++;
    if (m_wait >= 0) begin
      if (bus.mc_done || m_wait == TO - 1) begin
        if (!bus.mc_done) m_to = 1'b1;
        m_wait = -1;
      end else m_wait++;
    end else if (bus.branch_taken) m_pend = 1'b0;
    else if (m_pend) begin
      m_pend = 1'b0;
      m_wait = 0;
    end else if (!lu_now() && bus.id_mc_op) m_pend = 1'b1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic idle();
    bus.id_rs1 = '0; bus.id_rs2 = '0; bus.ex_rd = '0;
    bus.id_rs1_used = 1'b0; bus.id_rs2_used = 1'b0; bus.id_mc_op = 1'b0;
    bus.ex_mem_read = 1'b0; bus.branch_taken = 1'b0; bus.mc_done = 1'b0;
  endtask

  // Check against the model, and against a constant too when use_c is set.
  task automatic step(input string tag, input bit use_c, input logic [7:0] c);
    @(negedge clk);
    chk(tag, 32'(ctl_vec()), 32'(expect_ctl()));
    chk({tag, "_cnt"}, 32'(bus.stall_cnt), 32'(m_cnt));
    if (use_c) chk({tag, "_const"}, 32'(ctl_vec()), 32'(c));
    @(posedge clk);
    advance();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle();
    #2;
    chk("rst_ctl", 32'(ctl_vec()), 32'h0);
    chk("rst_cnt", 32'(bus.stall_cnt), 32'h0);
    m_wait = -1; m_pend = 1'b0; m_to = 1'b0; m_cnt = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic issue_mc();
    bus.id_mc_op = 1'b1;
    step("mc_issue", 1'b1, 8'h00);
    bus.id_mc_op = 1'b0;
    step("mc_pend", 1'b1, 8'h00);
  endtask

  initial begin
    vecs[0] = '{1, 5, 5, 0, 1, 0, 0, 4'b1101};
    vecs[1] = '{1, 0, 0, 0, 1, 0, 0, 4'b0000};
    vecs[2] = '{1, 5, 5, 0, 0, 0, 0, 4'b0000};
    vecs[3] = '{1, 7, 3, 7, 1, 1, 0, 4'b1101};
    vecs[4] = '{0, 5, 5, 0, 1, 0, 0, 4'b0000};
    vecs[5] = '{1, 5, 5, 0, 1, 0, 1, 4'b0011};
    vecs[6] = '{0, 0, 0, 0, 0, 0, 1, 4'b0011};
    vecs[7] = '{1, 9, 8, 10, 1, 1, 0, 4'b0000};
    idle();
    #1;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      bus.ex_mem_read = vecs[i].ld; bus.ex_rd = vecs[i].rd;
      bus.id_rs1 = vecs[i].rs1; bus.id_rs2 = vecs[i].rs2;
      bus.id_rs1_used = vecs[i].u1; bus.id_rs2_used = vecs[i].u2;
      bus.branch_taken = vecs[i].br;
      step($sformatf("vec%0d", i), 1'b1,
           {vecs[i].want[3], vecs[i].want[2], vecs[i].want[1], 1'b0, vecs[i].want[0], 3'b0});
    end
    idle();
    chk("vec_cnt", 32'(bus.stall_cnt), 32'd2);

    do_reset();
    issue_mc();
    for (int i = 0; i < 6; i++) step("mc_wait", 1'b1, 8'b11010110);
    bus.mc_done = 1'b1;
    step("mc_done", 1'b1, 8'b00000010);
    bus.mc_done = 1'b0;
    step("mc_after", 1'b1, 8'h00);
    chk("mc_cnt", 32'(bus.stall_cnt), 32'd6);

    do_reset();
    issue_mc();
    for (int i = 0; i < TO - 1; i++) step("to_wait", 1'b1, 8'b11010110);
    step("to_rel", 1'b1, 8'b00000010);
    for (int i = 0; i < 4; i++) step("to_sticky", 1'b1, 8'b00000001);
    chk("to_cnt", 32'(bus.stall_cnt), 32'(TO - 1));

    do_reset();
    issue_mc();
    for (int i = 0; i < 3; i++) step("rw_wait", 1'b1, 8'b11010110);
    do_reset();
    bus.mc_done = 1'b1;
    step("late_done", 1'b1, 8'h00);
    bus.mc_done = 1'b0;
    step("late_after", 1'b1, 8'h00);

    do_reset();
    bus.id_mc_op = 1'b1;
    step("pbr_issue", 1'b1, 8'h00);
    bus.id_mc_op = 1'b0;
    bus.branch_taken = 1'b1;
    step("pbr_br", 1'b1, 8'b00101000);
    bus.branch_taken = 1'b0;
    step("pbr_after", 1'b1, 8'h00);

    do_reset();
    bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd3; bus.id_rs2 = 5'd3; bus.id_rs2_used = 1'b1;
    for (int i = 0; i < 260; i++) step("sat", 1'b0, 8'h00);
    chk("sat_cnt", 32'(bus.stall_cnt), 32'd255);

    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bus.ex_mem_read  = 1'($urandom_range(0, 1));
      bus.ex_rd        = AW'($urandom_range(0, 3));
      bus.id_rs1       = AW'($urandom_range(0, 3));
      bus.id_rs2       = AW'($urandom_range(0, 3));
      bus.id_rs1_used  = 1'($urandom_range(0, 1));
      bus.id_rs2_used  = 1'($urandom_range(0, 1));
      bus.branch_taken = $urandom_range(0, 7) == 0;
      bus.mc_done      = $urandom_range(0, 9) == 0;
      bus.id_mc_op     = m_wait < 0 && !m_pend && $urandom_range(0, 5) == 0;
      step("rand", 1'b0, 8'h00);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage core.
- Drives the hold and flush controls of the PC register, the IF/ID register (ifid_hazarded, pipelineFlush), the ID/EX register and the EX/MEM register.
- Resolves three hazard sources:
  - load-use data hazards;
  - taken branches/jumps resolved in EX;
  - multi-cycle EX operations (FFT butterfly/MUL custom instructions), which wait for a done handshake under a timeout watchdog.

Parameters:
- REG_AW, 5: register-index width.
- CNT_W, 16: width of the stall performance counter.
- MC_TIMEOUT, 1024: maximum number of MC_WAIT cycles before forced release.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- id_rs1  in  REG_AW  rs1 index of the instruction in ID.
- id_rs2  in  REG_AW  rs2 index of the instruction in ID.
- id_rs1_used  in  1  ID instruction reads rs1.
- id_rs2_used  in  1  ID instruction reads rs2.
- id_mc_op  in  1  ID instruction is multi-cycle; it issues to EX next cycle.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_rd  in  REG_AW  destination of the instruction in EX.
- branch_taken  in  1  EX redirect (taken branch/jump).
- mc_done  in  1  multi-cycle unit result valid; one-cycle pulse.
- pc_hold  out  1  PC keeps its value.
- ifid_hold  out  1  drives ifid_hazarded.
- ifid_flush  out  1  drives pipelineFlush; IF/ID captures a NOP.
- idex_hold  out  1  ID/EX keeps contents.
- idex_bubble  out  1  ID/EX loads a NOP.
- exmem_bubble  out  1  EX/MEM loads a NOP.
- mc_busy  out  1  state is MC_WAIT.
- mc_timeout  out  1  sticky watchdog flag.
- stall_cnt  out  CNT_W  number of cycles with pc_hold=1.

Behaviour:
- Registered state: fsm state {RUN, MC_WAIT}, issue flag mc_pend, wait counter wcnt (ceil(log2(MC_TIMEOUT+1)) bits), mc_timeout, stall_cnt. All are cleared asynchronously on rst=0; state resets to RUN.
- Control outputs are combinational from state and inputs (zero latency). At reset, all control outputs are 0, mc_busy=0, mc_timeout=0, stall_cnt=0.
- Load-use hazard: lu = ex_mem_read && ex_rd!=0 && ((id_rs1_used && id_rs1==ex_rd) || (id_rs2_used && id_rs2==ex_rd)).
- RUN, priority high to low:
  1. branch_taken=1: ifid_flush=1 and idex_bubble=1; no hold; lu and id_mc_op are ignored this cycle (the ID instruction is squashed).
  2. lu=1: pc_hold=1, ifid_hold=1, idex_bubble=1 for exactly that cycle. Repeats only while the condition holds.
  3. id_mc_op=1 (no lu): the instruction advances normally; set mc_pend. Next cycle the op is in EX, mc_pend clears, state goes to MC_WAIT and wcnt=0.
  4. Otherwise all controls are 0.
- mc_pend=1 with branch_taken=1 in the same cycle: not possible (the op is in EX, not a branch). Defensively, branch wins and mc_pend clears without entering MC_WAIT.
- MC_WAIT:
  - pc_hold=1, ifid_hold=1, idex_hold=1, exmem_bubble=1, mc_busy=1.
  - branch_taken is ignored.
  - wcnt increments each cycle.
  - mc_done=1: in that same cycle all holds and bubbles deassert (result advances); next state RUN.
  - wcnt==MC_TIMEOUT-1 without mc_done: same release as mc_done; set mc_timeout (sticky until reset); next state RUN.
  - mc_done in RUN is ignored.
- A hazard on the instruction behind the mc op is evaluated normally in the first RUN cycle after release.
- stall_cnt increments on every cycle with pc_hold=1 and saturates at all-ones.
- Reset mid-MC_WAIT: immediate return to RUN with all outputs 0; a late mc_done is then ignored.

Test Plan:
- ex_mem_read=1, ex_rd=5, id_rs1=5, id_rs1_used=1 for one cycle -> pc_hold=ifid_hold=idex_bubble=1 in that cycle only; stall_cnt=1.
- Same as above but ex_rd=0, or id_rs1_used=0 -> no stall; all controls 0.
- branch_taken=1 concurrent with the lu condition -> ifid_flush=idex_bubble=1, pc_hold=0, stall_cnt unchanged.
- id_mc_op pulse, then mc_done 6 cycles after entering MC_WAIT -> mc_busy and holds high for 6 cycles, deassert in the mc_done cycle; stall_cnt=6.
- id_mc_op with no mc_done -> release after exactly MC_TIMEOUT cycles; mc_timeout=1 and stays 1; state returns to RUN.
- rst driven low 3 cycles into MC_WAIT -> outputs 0 immediately; mc_done after reset release produces no effect.
